// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bundle: two write requesters, issue-stage claim
// and hazard-check ports, scoreboard view and register-file drive.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 1 << ADDR_W;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              claim_valid;
  logic [ADDR_W-1:0] claim_addr;

  logic [ADDR_W-1:0] chk_addr_1;
  logic [ADDR_W-1:0] chk_addr_2;
  logic              chk_busy_1;
  logic              chk_busy_2;

  logic [NREG-1:0]   busy_vec;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output claim_valid, claim_addr,
    output chk_addr_1, chk_addr_2,
    input  chk_busy_1, chk_busy_2,
    input  busy_vec,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  claim_valid, claim_addr,
    input  chk_addr_1, chk_addr_2,
    output chk_busy_1, chk_busy_2,
    output busy_vec,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register file with a
// pending-write scoreboard used for source-operand hazard checks.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic              ptr_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   set_vec;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              g_live;

  // Ready is masked by reset so nothing is accepted while held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case ({bus.req0_valid, bus.req1_valid})
      2'b11: begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end
      2'b10: gnt0 = 1'b1;
      2'b01: gnt1 = 1'b1;
      default: ;
    endcase
    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;
  end

  assign any_gnt = gnt0 | gnt1;
  assign g_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign g_data  = gnt1 ? bus.req1_data : bus.req0_data;
  assign g_live  = any_gnt && (g_addr != '0);

  // A claim in the same cycle as a grant wins: newer producer outstanding.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (g_live) begin
      clr_vec = ONE << g_addr;
    end
    if (bus.claim_valid && (bus.claim_addr != '0)) begin
      set_vec = ONE << bus.claim_addr;
    end
    busy_nxt    = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q  <= busy_nxt;
      wr_en_q <= g_live;
      if (any_gnt) begin
        ptr_q     <= gnt0;
        wr_addr_q <= g_addr;
        wr_data_q <= g_data;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.chk_busy_1 = busy_q[bus.chk_addr_1];
  assign bus.chk_busy_2 = busy_q[bus.chk_addr_2];
  assign bus.busy_vec   = busy_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset corner case,
// then random traffic against a behavioural scoreboard model.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        cv;
    logic [4:0]  ca;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        r0;
    logic        r1;
    logic        b1;
    logic        b2;
    logic        we;
    logic        cmp_ad;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl [13];

  int          m_pref;
  bit [31:0]   m_busy;
  bit          m_we;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
    bus.claim_valid = 1'b0;
    bus.claim_addr  = '0;
    bus.chk_addr_1  = '0;
    bus.chk_addr_2  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 64'(bus.rf_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.rf_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.rf_wr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'd0;
    if (r < 6) return 5'($urandom_range(1, 6));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    //       v0 a0 d0          v1 a1 d1     cv ca c1 c2 r0 r1 b1 b2 we cmp wa wd           busy
    tbl[0]  = '{1, 1, 'h11,       1, 2, 'h22, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 'h11,       0};
    tbl[1]  = '{1, 1, 'h11,       1, 2, 'h22, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 'h22,       0};
    tbl[2]  = '{1, 1, 'h11,       1, 2, 'h22, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 'h11,       0};
    tbl[3]  = '{1, 1, 'h11,       1, 2, 'h22, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 'h22,       0};
    tbl[4]  = '{1, 5, 'hDEADBEEF, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 5, 'hDEADBEEF, 0};
    tbl[5]  = '{0, 0, 0,          0, 0, 0,    1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'hDEADBEEF, 'h80};
    tbl[6]  = '{0, 0, 0,          1, 7, 'h77, 0, 0, 7, 0, 0, 1, 1, 0, 1, 1, 7, 'h77,       0};
    tbl[7]  = '{1, 9, 'h99,       0, 0, 0,    1, 9, 7, 0, 1, 0, 0, 0, 1, 1, 9, 'h99,       'h200};
    tbl[8]  = '{1, 0, 'h1234,     0, 0, 0,    1, 0, 9, 7, 1, 0, 1, 0, 0, 0, 0, 0,          'h200};
    tbl[9]  = '{0, 0, 0,          0, 0, 0,    0, 0, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0,          'h200};
    tbl[10] = '{1, 3, 'h33,       1, 4, 'h44, 0, 0, 0, 9, 0, 1, 0, 1, 1, 1, 4, 'h44,       'h200};
    tbl[11] = '{1, 3, 'h33,       0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 3, 'h33,       'h200};
    tbl[12] = '{0, 0, 0,          1, 6, 'h66, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 6, 'h66,       'h200};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      bus.req0_valid  = tbl[i].v0;
      bus.req0_addr   = tbl[i].a0;
      bus.req0_data   = tbl[i].d0;
      bus.req1_valid  = tbl[i].v1;
      bus.req1_addr   = tbl[i].a1;
      bus.req1_data   = tbl[i].d1;
      bus.claim_valid = tbl[i].cv;
      bus.claim_addr  = tbl[i].ca;
      bus.chk_addr_1  = tbl[i].c1;
      bus.chk_addr_2  = tbl[i].c2;
      #2;
      chk($sformatf("v%0d_ready0", i), 64'(bus.req0_ready), 64'(tbl[i].r0));
      chk($sformatf("v%0d_ready1", i), 64'(bus.req1_ready), 64'(tbl[i].r1));
      chk($sformatf("v%0d_chk1", i), 64'(bus.chk_busy_1), 64'(tbl[i].b1));
      chk($sformatf("v%0d_chk2", i), 64'(bus.chk_busy_2), 64'(tbl[i].b2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_en", i), 64'(bus.rf_wr_en), 64'(tbl[i].we));
      chk($sformatf("v%0d_busy", i), 64'(bus.busy_vec), 64'(tbl[i].busy));
      if (tbl[i].cmp_ad) begin
        chk($sformatf("v%0d_wr_addr", i), 64'(bus.rf_wr_addr), 64'(tbl[i].wa));
        chk($sformatf("v%0d_wr_data", i), 64'(bus.rf_wr_data), 64'(tbl[i].wd));
      end
      @(negedge clk);
    end

    // Reset asserted mid-cycle with claims pending and a write in flight.
    idle_inputs();
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd3;
    @(negedge clk);
    bus.claim_addr  = 5'd4;
    bus.req0_valid  = 1'b1;
    bus.req0_addr   = 5'd10;
    bus.req0_data   = 32'hAA;
    @(negedge clk);
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd11;
    bus.req0_data  = 32'hB1;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd12;
    bus.req1_data  = 32'hC2;
    #1;
    chk("pre_rst_wr_en", 64'(bus.rf_wr_en), 64'd1);
    chk("pre_rst_busy", 64'(bus.busy_vec), 64'h218);
    chk("pre_rst_ready1", 64'(bus.req1_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("mid_rst_wr_en", 64'(bus.rf_wr_en), 64'd0);
    chk("mid_rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_ready0", 64'(bus.req0_ready), 64'd1);
    chk("post_rst_ready1", 64'(bus.req1_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_wr_addr", 64'(bus.rf_wr_addr), 64'd11);
    @(negedge clk);

    // Random traffic against the reference model.
    do_reset();
    m_pref = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    begin
      bit hold0;
      bit hold1;
      int g;
      logic [4:0]  ga;
      logic [31:0] gd;
      hold0 = 1'b0;
      hold1 = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if (!hold0) begin
          bus.req0_valid = 1'($urandom_range(0, 1));
          bus.req0_addr  = pick_addr();
          bus.req0_data  = $urandom;
        end
        if (!hold1) begin
          bus.req1_valid = 1'($urandom_range(0, 1));
          bus.req1_addr  = pick_addr();
          bus.req1_data  = $urandom;
        end
        bus.claim_valid = ($urandom_range(0, 2) == 0);
        bus.claim_addr  = pick_addr();
        bus.chk_addr_1  = pick_addr();
        bus.chk_addr_2  = 5'($urandom_range(0, 31));

        if (bus.req0_valid && bus.req1_valid) g = m_pref;
        else if (bus.req0_valid) g = 0;
        else if (bus.req1_valid) g = 1;
        else g = -1;
        ga = (g == 1) ? bus.req1_addr : bus.req0_addr;
        gd = (g == 1) ? bus.req1_data : bus.req0_data;

        #2;
        chk("rnd_ready0", 64'(bus.req0_ready), 64'(g == 0));
        chk("rnd_ready1", 64'(bus.req1_ready), 64'(g == 1));
        chk("rnd_chk1", 64'(bus.chk_busy_1), 64'(m_busy[bus.chk_addr_1]));
        chk("rnd_chk2", 64'(bus.chk_busy_2), 64'(m_busy[bus.chk_addr_2]));

        @(posedge clk);
        m_we = 1'b0;
        if (g >= 0) begin
          m_pref = 1 - g;
          m_wa   = ga;
          m_wd   = gd;
          if (ga != 0) begin
            m_we       = 1'b1;
            m_busy[ga] = 1'b0;
          end
        end
        if (bus.claim_valid && bus.claim_addr != 0) begin
          m_busy[bus.claim_addr] = 1'b1;
        end
        hold0 = bus.req0_valid && (g != 0);
        hold1 = bus.req1_valid && (g != 1);

        #1;
        chk("rnd_wr_en", 64'(bus.rf_wr_en), 64'(m_we));
        chk("rnd_busy", 64'(bus.busy_vec), 64'(m_busy));
        if (m_we) begin
          chk("rnd_wr_addr", 64'(bus.rf_wr_addr), 64'(m_wa));
          chk("rnd_wr_data", 64'(bus.rf_wr_data), 64'(m_wd));
        end
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
